// File: rtl/countdown_pkg.sv
// Shared constants and helpers for the countdown timer: segment codes and counter sizing.
package countdown_pkg;

  localparam logic [7:0] SEG_0     = 8'hFC;
  localparam logic [7:0] SEG_1     = 8'h60;
  localparam logic [7:0] SEG_2     = 8'hDA;
  localparam logic [7:0] SEG_3     = 8'hF2;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'hB6;
  localparam logic [7:0] SEG_6     = 8'hBE;
  localparam logic [7:0] SEG_7     = 8'hE0;
  localparam logic [7:0] SEG_8     = 8'hFE;
  localparam logic [7:0] SEG_9     = 8'hF6;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Bits needed to hold 0..v-1 (minimum 1).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned x;
    int unsigned r;
    x = (v > 1) ? v - 1 : 1;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((x >> i) != 0) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_dec.sv
// Combinational BCD digit to 7-segment {a..g,dp} decoder, active-high segments.
module seg7_dec
  import countdown_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [7:0] seg_o
);

  assign seg_o = seg_code(bcd_i);

endmodule

// File: rtl/countdown_timer.sv
// BCD countdown timer with tick prescaler, saturating load, expiry blink and
// multiplexed 7-segment display drive.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 50000000,
  parameter int unsigned DIGITS   = 2,
  parameter logic [31:0] START    = 32'h30,
  parameter int unsigned SCAN_DIV = 25000,
  parameter int unsigned BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  pause,
  output logic [DIGITS-1:0]     digit_con,
  output logic [7:0]            digit_seg,
  output logic [4*DIGITS-1:0]   count,
  output logic                  expired,
  output logic                  expire_pulse
);

  localparam int unsigned CW = 4 * DIGITS;
  localparam int unsigned PW = clog2(CLK_HZ);
  localparam int unsigned SW = clog2(SCAN_DIV);
  localparam int unsigned IW = clog2(DIGITS);

  localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_HZ / 2);
  localparam logic [SW-1:0] SCAN_MAX   = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX    = IW'(DIGITS - 1);
  localparam logic [CW-1:0] START_V    = CW'(START);

  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [SW-1:0]     scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]     scan_idx_q, scan_idx_d;
  logic [DIGITS-1:0] digit_con_q, digit_con_d;
  logic [7:0]        digit_seg_q, digit_seg_d;
  logic              expired_q, expired_d;
  logic              pulse_q, pulse_d;

  logic [CW-1:0] load_sat, count_dec;
  logic          borrow, count_zero, running, tick;
  logic [3:0]    nibble_c;
  logic [7:0]    seg_c;
  logic          upper_zero, blank;

  // Saturate load digits to 9 and form the BCD decrement with digit borrow.
  always_comb begin
    load_sat  = '0;
    count_dec = '0;
    borrow    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      load_sat[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
      if (!borrow) begin
        count_dec[4*i +: 4] = count_q[4*i +: 4];
      end else if (count_q[4*i +: 4] == 4'd0) begin
        count_dec[4*i +: 4] = 4'd9;
      end else begin
        count_dec[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
        borrow              = 1'b0;
      end
    end
  end

  assign count_zero = (count_q == '0);
  assign running    = !pause && !load && !count_zero;
  assign tick       = running && (presc_q == PRESC_MAX);

  // Count and prescaler; at zero the prescaler free-runs only to pace the blink.
  always_comb begin
    count_d = count_q;
    presc_d = presc_q;
    pulse_d = 1'b0;
    if (load) begin
      count_d = load_sat;
      presc_d = '0;
    end else if (running || count_zero) begin
      presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
      if (tick) begin
        count_d = count_dec;
        pulse_d = (count_dec == '0);
      end
    end
    expired_d = (count_d == '0);
  end

  // Digit scan and segment select, both computed from next state so they register together.
  always_comb begin
    scan_cnt_d = (scan_cnt_q == SCAN_MAX) ? '0 : scan_cnt_q + SW'(1);
    scan_idx_d = scan_idx_q;
    if (scan_cnt_q == SCAN_MAX) begin
      scan_idx_d = (scan_idx_q == IDX_MAX) ? '0 : scan_idx_q + IW'(1);
    end
    digit_con_d = DIGITS'(1) << scan_idx_d;
    nibble_c    = count_d[{scan_idx_d, 2'b00} +: 4];
    upper_zero  = ((count_d >> {scan_idx_d, 2'b00}) == '0) && (scan_idx_d != '0);
    blank       = ((BLANK_LZ != 0) && upper_zero) ||
                  (expired_d && (presc_d >= PRESC_HALF));
    digit_seg_d = blank ? SEG_BLANK : seg_c;
  end

  seg7_dec u_seg7_dec (
    .bcd_i (nibble_c),
    .seg_o (seg_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= START_V;
      presc_q     <= '0;
      scan_cnt_q  <= '0;
      scan_idx_q  <= '0;
      digit_con_q <= DIGITS'(1);
      digit_seg_q <= seg_code(START_V[3:0]);
      expired_q   <= (START_V == '0);
      pulse_q     <= 1'b0;
    end else begin
      count_q     <= count_d;
      presc_q     <= presc_d;
      scan_cnt_q  <= scan_cnt_d;
      scan_idx_q  <= scan_idx_d;
      digit_con_q <= digit_con_d;
      digit_seg_q <= digit_seg_d;
      expired_q   <= expired_d;
      pulse_q     <= pulse_d;
    end
  end

  assign count        = count_q;
  assign digit_con    = digit_con_q;
  assign digit_seg    = digit_seg_q;
  assign expired      = expired_q;
  assign expire_pulse = pulse_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed scoreboard bench for countdown_timer (CLK_HZ=10, SCAN_DIV=2, DIGITS=2, START=0x30).
module tb_countdown_timer;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [7:0] load_val;
  logic       pause;
  logic [1:0] digit_con;
  logic [7:0] digit_seg;
  logic [7:0] count;
  logic       expired;
  logic       expire_pulse;

  countdown_timer #(
    .CLK_HZ   (10),
    .DIGITS   (2),
    .START    (32'h30),
    .SCAN_DIV (2),
    .BLANK_LZ (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (load),
    .load_val     (load_val),
    .pause        (pause),
    .digit_con    (digit_con),
    .digit_seg    (digit_seg),
    .count        (count),
    .expired      (expired),
    .expire_pulse (expire_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned edge_n = 0;

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    logic [7:0] t [10];
    t = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};
    return t[d];
  endfunction

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0:       return 32'(count);
      1:       return 32'(digit_con);
      2:       return 32'(digit_seg);
      3:       return 32'(expired);
      4:       return 32'(expire_pulse);
      default: return 32'(dut.presc_q);
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      n_cmp++;
      assert (obs === e.val) else begin
        n_err++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      edge_n++;
    end
    #1;
  endtask

  // Expected display follows from the scan position implied by edges since reset release.
  task automatic expect_state(input string tag, input logic [7:0] cnt, input int presc,
                              input bit exp_f, input bit pulse);
    int         idx;
    logic [3:0] dig;
    logic [7:0] seg;
    idx = int'((edge_n / 2) % 2);
    dig = (idx == 1) ? cnt[7:4] : cnt[3:0];
    if (exp_f && presc >= 5)             seg = 8'h00;
    else if (idx == 1 && cnt[7:4] == 0)  seg = 8'h00;
    else                                 seg = seg_of(dig);
    push({tag, "_count"}, 0, 32'(cnt));
    push({tag, "_con"},   1, (idx == 1) ? 32'h2 : 32'h1);
    push({tag, "_seg"},   2, 32'(seg));
    push({tag, "_exp"},   3, 32'(exp_f));
    push({tag, "_pulse"}, 4, 32'(pulse));
    push({tag, "_presc"}, 5, 32'(presc));
    drain();
  endtask

  task automatic do_load(input logic [7:0] v);
    load     = 1'b1;
    load_val = v;
    cyc(1);
    load     = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    load     = 1'b0;
    load_val = 8'h00;
    pause    = 1'b0;
    cyc(2);
    rst_n  = 1'b1;
    edge_n = 0;
    expect_state("reset", 8'h30, 0, 1'b0, 1'b0);

    cyc(2);
    expect_state("scan2", 8'h30, 2, 1'b0, 1'b0);
    cyc(8);
    expect_state("borrow", 8'h29, 0, 1'b0, 1'b0);

    cyc(289);
    expect_state("pre_zero", 8'h01, 9, 1'b0, 1'b0);
    cyc(1);
    expect_state("zero", 8'h00, 0, 1'b1, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      cyc(1);
      expect_state("blink", 8'h00, k % 10, 1'b1, 1'b0);
    end

    do_load(8'h17);
    expect_state("load17", 8'h17, 0, 1'b0, 1'b0);
    cyc(3);
    expect_state("run17", 8'h17, 3, 1'b0, 1'b0);
    pause = 1'b1;
    cyc(1);
    expect_state("pause1", 8'h17, 3, 1'b0, 1'b0);
    cyc(24);
    expect_state("pause25", 8'h17, 3, 1'b0, 1'b0);
    pause = 1'b0;
    cyc(6);
    expect_state("pre_tick", 8'h17, 9, 1'b0, 1'b0);

    do_load(8'h24);
    expect_state("load_vs_tick", 8'h24, 0, 1'b0, 1'b0);
    do_load(8'h3C);
    expect_state("sat39", 8'h39, 0, 1'b0, 1'b0);
    do_load(8'h05);
    expect_state("lz_tens", 8'h05, 0, 1'b0, 1'b0);
    cyc(2);
    expect_state("lz_ones", 8'h05, 2, 1'b0, 1'b0);
    do_load(8'h00);
    expect_state("load_zero", 8'h00, 0, 1'b1, 1'b0);
    cyc(1);
    expect_state("load_zero2", 8'h00, 1, 1'b1, 1'b0);

    do_load(8'h12);
    expect_state("load12", 8'h12, 0, 1'b0, 1'b0);
    cyc(2);
    load     = 1'b1;
    load_val = 8'h77;
    #2;
    rst_n  = 1'b0;
    edge_n = 0;
    #1;
    expect_state("async_rst", 8'h30, 0, 1'b0, 1'b0);
    load = 1'b0;
    #1;
    rst_n = 1'b1;
    cyc(1);
    expect_state("post_rst", 8'h30, 1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
